// File: rtl/alu_pkg.sv
// Shared types for the ALU front-end arbiter: opcodes, flag layout and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SLTU = 4'd7,
        SRA  = 4'd8,
        SLT  = 4'd9
    } alu_op_e;

    localparam int ALU_OP_LAST = int'(SLT);

    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
        logic carry;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr wins,
// reported both as a one-hot grant and as a binary index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_cand [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_cand[k] = IW'((int'(i_ptr) + k) % N);
        end
    end

    // Walk from the farthest candidate back to i_ptr so the closest valid one is written last.
    always_comb begin
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_idx = w_cand[k];
                o_any = 1'b1;
            end
        end
        o_grant[o_idx] = o_any;
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational ALU among N_REQ requesters,
// with registered operands and a held response until the owner accepts it.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int ALUcontrolWidth = 4,
    parameter int N_REQ           = 2,
    parameter int OP_LAST         = ALU_OP_LAST
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*ALUcontrolWidth-1:0]  req_op,
    input  logic [N_REQ*32-1:0]               req_srcA,
    input  logic [N_REQ*32-1:0]               req_srcB,
    output logic [N_REQ-1:0]                  rsp_valid,
    input  logic [N_REQ-1:0]                  rsp_ready,
    output logic [31:0]                       rsp_result,
    output logic [3:0]                        rsp_flags,
    output logic                              rsp_err,
    output logic [ALUcontrolWidth-1:0]        alu_ctrl,
    output logic [31:0]                       alu_srcA,
    output logic [31:0]                       alu_srcB,
    input  logic [31:0]                       alu_result,
    input  logic [3:0]                        alu_flags
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e                 r_state;
    logic [IW-1:0]              r_ptr;
    logic [IW-1:0]              r_owner;
    logic [ALUcontrolWidth-1:0] r_op;
    logic [31:0]                r_srcA;
    logic [31:0]                r_srcB;
    logic [31:0]                r_result;
    alu_flags_t                 r_flags;
    logic                       r_err;
    logic [N_REQ-1:0]           r_rsp_valid;

    logic [N_REQ-1:0]           w_grant;
    logic [IW-1:0]              w_idx;
    logic                       w_any;
    logic [IW-1:0]              w_ptr_next;
    logic [N_REQ-1:0]           w_owner_1h;
    logic                       w_illegal;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_ptr_next = w_idx + 1'b1;
        if (int'(w_idx) == N_REQ - 1) begin
            w_ptr_next = '0;
        end
        w_owner_1h          = '0;
        w_owner_1h[r_owner] = 1'b1;
    end

    assign w_illegal = (r_op > ALUcontrolWidth'(OP_LAST));

    // Gated by rst so no grant is visible while the block is held in reset.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_err    = r_err;
    assign alu_ctrl   = r_op;
    assign alu_srcA   = r_srcA;
    assign alu_srcB   = r_srcB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_op        <= '0;
            r_srcA      <= '0;
            r_srcB      <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op    <= req_op[w_idx*ALUcontrolWidth +: ALUcontrolWidth];
                        r_srcA  <= req_srcA[w_idx*32 +: 32];
                        r_srcB  <= req_srcB[w_idx*32 +: 32];
                        r_owner <= w_idx;
                        r_ptr   <= w_ptr_next;
                        r_state <= EXEC;
                    end
                end
                // Illegal opcodes still spend this cycle, but the ALU output is discarded.
                EXEC: begin
                    if (w_illegal) begin
                        r_result <= '0;
                        r_flags  <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= alu_result;
                        r_flags  <= alu_flags;
                        r_err    <= 1'b0;
                    end
                    r_rsp_valid <= w_owner_1h;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
